keypad_uart_tx: RTL and testbench
=================================

# keypad_uart_tx

Parametrised keypad-to-UART transmitter: collects up to DIGITS decimal digits from the keypad scanner, drives them packed to the display decoders, and on submit serialises them as ASCII characters followed by a terminator byte on txd. It replaces the fixed four-digit transmitter between the keypad front end and the remote calculator link, and adds a busy flag, a digit count, a configurable terminator and optional parity.

## Interface
- DIGITS, 4: digit buffer depth, at least 1.
- CLKS_PER_BIT, 5208: clk cycles per UART bit (50 MHz / 9600), at least 2.
- TERM, 8'h0D: terminator byte sent after the last digit.
- clk  in  1: system clock, rising edge.
- reset  in  1: synchronous, active-high reset.
- num  in  4: keypad digit value, valid while numPressed is high.
- numPressed  in  1: key-held level; may stay high for multiple cycles.
- clear  in  1: level; edge-detected; empties the buffer.
- submit  in  1: level; edge-detected; starts transmission.
- digits  out  4*DIGITS: BCD buffer, newest digit in [3:0], unused slots 0.
- count  out  $clog2(DIGITS+1): number of valid digits.
- busy  out  1: high from transmission start until the final stop bit ends.
- txd  out  1: UART serial output, idle high.

## Operation
- Inputs are edge-detected with one registered history bit each. An event is the cycle in which the input is high and its history bit is low.
- Press event: num ≤ 9 shifts digits left by 4 and inserts num at [3:0]. The oldest digit falls off when the buffer is full. count increments and saturates at DIGITS. num ≥ 10 is ignored.
- Clear event: digits = 0, count = 0.
- Same-cycle priority: submit > clear > press. Lower-priority events in that cycle are dropped.
- While busy, press, clear and submit events are ignored. Edge history still updates.
- Submit event with count = 0: no action.
- Submit event with count > 0:
  - latch digits and count into the transmit shadow and assert busy;
  - send count frames, oldest digit first, each byte 8'h30 + digit;
  - then send one frame of TERM;
  - when done, clear digits and count and deassert busy.
- Frame format: start 0, 8 data bits LSB first, [parity], stop 1. Frames are sent back to back with no idle gap.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START on an accepted submit.
  - START→DATA after CLKS_PER_BIT cycles.
  - DATA→PARITY, or →STOP when parity is out, after 8 bits.
  - PARITY→STOP.
  - STOP→START if bytes remain, else →IDLE.
- Counters: bit-cycle counter 0..CLKS_PER_BIT-1; bit index 0..7; byte index 0..count (index count selects TERM).

## Timing
- Reset values: txd = 1, busy = 0, count = 0, digits = 0, FSM = IDLE, all counters 0.
- Press event in cycle k: digits and count update at the k+1 edge.
- Submit event in cycle k: busy = 1 and txd = 0 from edge k+1.
- Every bit lasts exactly CLKS_PER_BIT cycles.
- Total busy time = (count+1) × F × CLKS_PER_BIT cycles. F = 10, or 11 with parity.
- busy falls, and count/digits clear, on the same edge that ends the last stop bit.
- Reset mid-frame: on the next edge txd = 1 and busy = 0. No partial frame resumes.
- txd is a direct register output, glitch-free.

## Configuration
- TX_PARITY_EN defined: one even-parity bit (XOR of the data byte) is inserted between data and stop. F = 11.
- TX_PARITY_EN undefined: the PARITY state and its logic are not compiled. Frames are 8N1 and F = 10.

## Structure
- Package keypad_tx_pkg holds:
  - the FSM state enum;
  - ASCII_ZERO = 8'h30;
  - FRAME_BITS, derived from TX_PARITY_EN;
  - a function busy_cycles(count, clks) used by both RTL assertions and the bench.
- Sub-module uart_tx_byte: one-byte serialiser (START/DATA/PARITY/STOP, bit timer) with a start/byte/done handshake.
- Top level holds the edge detectors, the digit buffer, the byte sequencer and the IDLE handling.

## Test plan
All scenarios use CLKS_PER_BIT = 4 and DIGITS = 4.
- Reset: hold reset 2 cycles → txd = 1, busy = 0, count = 0, digits = 16'h0000.
- Single press: num = 8 with numPressed high 2 cycles → exactly one capture; count = 1, digits = 16'h0008.
- Submit after "8": submit pulse →
  - txd from the next edge: 0, 0,0,0,1,1,1,0,0, 1 (byte 0x38), then the 0x0D frame, each bit 4 cycles;
  - busy high for 80 cycles;
  - then count = 0.
- Buffer limits: press 1,2,3,4,5 then num = 10 → digits = 16'h2345, count = 4; the value 10 is ignored.
- Edge cases:
  - submit with count = 0 → txd stays 1 and busy stays 0;
  - press and clear in the same cycle → buffer empty;
  - press during busy → buffer unchanged.
- Reset mid-frame: assert reset during a data bit → next edge txd = 1, busy = 0, count = 0.
- Parity build (TX_PARITY_EN): byte 0x38 carries parity bit 1; busy lasts 88 cycles.

Source files
------------

// File: rtl/keypad_tx_pkg.sv
// keypad_tx_pkg: shared types, constants and helpers for the keypad-to-UART
// transmitter (keypad_uart_tx and its serialiser uart_tx_byte).
// Build macro: TX_PARITY_EN -- when defined every frame carries one even-parity
// bit between the data bits and the stop bit (11-bit frames instead of 10).
package keypad_tx_pkg;

    // Serialiser states; PARITY only exists in the parity build.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_e;

    localparam logic [7:0] ASCII_ZERO = 8'h30;

`ifdef TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    // Cycles busy stays high for a transmission of 'count' digits plus terminator.
    function automatic int unsigned busy_cycles(input int unsigned count, input int unsigned clks);
        return (count + 32'd1) * 32'(FRAME_BITS) * clks;
    endfunction

    // Even parity over one data byte: XOR of all bits.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/keypad_uart_tx_chk.sv
// keypad_uart_tx_chk: run-time checks on the transmitter outputs.
//   - busy stays high for exactly busy_cycles(count, CLKS_PER_BIT) cycles
//   - txd is high whenever busy is low
// Ports: clk, reset, busy, txd, count (observed design outputs).
module keypad_uart_tx_chk
    import keypad_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CW           = 3
) (
    input logic          clk,
    input logic          reset,
    input logic          busy,
    input logic          txd,
    input logic [CW-1:0] count
);
    logic        busy_q_r;
    int unsigned run_r;
    int unsigned exp_r;

    // Measure each busy window and compare against the expected length.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q_r <= 1'b0;
            run_r    <= 32'd0;
            exp_r    <= 32'd0;
        end else begin
            busy_q_r <= busy;
            if (busy && !busy_q_r) begin
                run_r <= 32'd1;
                exp_r <= busy_cycles(32'(count), 32'(CLKS_PER_BIT));
            end else if (busy) begin
                run_r <= run_r + 32'd1;
            end else if (busy_q_r) begin
                assert (run_r == exp_r)
                else $error("busy window %0d cycles, expected %0d", run_r, exp_r);
            end else begin
                run_r <= 32'd0;
            end
            assert (busy || txd)
            else $error("txd low while not busy");
        end
    end

endmodule

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: one-byte UART serialiser (start, 8 data bits LSB first,
// optional even parity, stop), each bit CLKS_PER_BIT clk cycles.
// Build macro: TX_PARITY_EN enables the PARITY state.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   start      : load 'data' and begin a frame (sampled in IDLE, or in the
//                last stop cycle for back-to-back frames)
//   data       : byte to send
//   done       : high during the final cycle of the stop bit
//   txd        : registered serial output, idle high
module uart_tx_byte
    import keypad_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       done,
    output logic       txd
);
    localparam int             CCW    = $clog2(CLKS_PER_BIT);
    localparam logic [CCW-1:0] LAST_C = CCW'(CLKS_PER_BIT - 1);

    tx_state_e      state_r, state_s;
    logic [CCW-1:0] clk_cnt_r, clk_cnt_s;
    logic [2:0]     bit_idx_r, bit_idx_s;
    logic [7:0]     data_r, data_s;
    logic           txd_r, txd_s;
    logic           bit_end_s;

    assign bit_end_s = (clk_cnt_r == LAST_C);
    assign done      = (state_r == STOP) && bit_end_s;
    assign txd       = txd_r;

    // Next-state, bit timer and next txd value.
    always_comb begin
        state_s   = state_r;
        bit_idx_s = bit_idx_r;
        data_s    = data_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = START;
                    data_s  = data;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) state_s = DATA;
                else           state_s = START;
            end
            DATA: begin
                if (bit_end_s) begin
                    if (bit_idx_r == 3'd7) begin
                        bit_idx_s = 3'd0;
`ifdef TX_PARITY_EN
                        state_s   = PARITY;
`else
                        state_s   = STOP;
`endif
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_s = DATA;
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                if (bit_end_s) state_s = STOP;
                else           state_s = PARITY;
            end
`endif
            STOP: begin
                if (bit_end_s) begin
                    // A start in the last stop cycle chains the next frame with no gap.
                    if (start) begin
                        state_s = START;
                        data_s  = data;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s   = IDLE;
                bit_idx_s = 3'd0;
            end
        endcase

        if (state_r == IDLE) clk_cnt_s = '0;
        else if (bit_end_s)  clk_cnt_s = '0;
        else                 clk_cnt_s = clk_cnt_r + CCW'(1);

        // txd is computed from the next state so the output register changes
        // on the same edge as the state.
        case (state_s)
            IDLE:    txd_s = 1'b1;
            START:   txd_s = 1'b0;
            DATA:    txd_s = data_s[bit_idx_s];
`ifdef TX_PARITY_EN
            PARITY:  txd_s = even_parity(data_s);
`endif
            STOP:    txd_s = 1'b1;
            default: txd_s = 1'b1;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            clk_cnt_r <= '0;
            bit_idx_r <= 3'd0;
            data_r    <= 8'h00;
            txd_r     <= 1'b1;
        end else begin
            state_r   <= state_s;
            clk_cnt_r <= clk_cnt_s;
            bit_idx_r <= bit_idx_s;
            data_r    <= data_s;
            txd_r     <= txd_s;
        end
    end

endmodule

// File: rtl/keypad_uart_tx.sv
// keypad_uart_tx: collects up to DIGITS keypad digits, shows them packed as
// BCD, and on submit sends them as ASCII (oldest first) plus a TERM byte.
// Build macro: TX_PARITY_EN adds an even-parity bit to every frame.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   num         : keypad digit, valid while numPressed is high
//   numPressed  : key-held level (rising edge = press)
//   clear       : level, rising edge empties the buffer
//   submit      : level, rising edge starts transmission
//   digits      : BCD buffer, newest digit in [3:0], unused slots 0
//   count       : number of valid digits
//   busy        : high from transmission start to end of the final stop bit
//   txd         : UART output, idle high
module keypad_uart_tx
    import keypad_tx_pkg::*;
#(
    parameter int         DIGITS       = 4,
    parameter int         CLKS_PER_BIT = 5208,
    parameter logic [7:0] TERM         = 8'h0D
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3:0]                   num,
    input  logic                         numPressed,
    input  logic                         clear,
    input  logic                         submit,
    output logic [4*DIGITS-1:0]          digits,
    output logic [$clog2(DIGITS+1)-1:0]  count,
    output logic                         busy,
    output logic                         txd
);
    localparam int            DW     = 4 * DIGITS;
    localparam int            CW     = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] FULL_C = CW'(DIGITS);

    logic          np_hist_r, clear_hist_r, submit_hist_r;
    logic          press_ev_s, clear_ev_s, submit_ev_s;
    logic [DW-1:0] digits_r, digits_s, sh_digits_r, sh_digits_s;
    logic [CW-1:0] count_r, count_s, sh_count_r, sh_count_s;
    logic [CW-1:0] idx_r, idx_s;
    logic          busy_r, busy_s;
    logic          start_s, done_s;
    logic [7:0]    tx_byte_s;

    // Byte 'idx' of a transmission: digits oldest first, then TERM at idx == cnt.
    function automatic logic [7:0] pick_byte(input logic [DW-1:0] dbuf,
                                             input logic [CW-1:0] cnt,
                                             input logic [CW-1:0] idx);
        logic [CW-1:0] slot;
        logic [DW-1:0] sh;
        slot = cnt - idx - CW'(1);
        sh   = dbuf >> {slot, 2'b00};
        if (idx < cnt) return ASCII_ZERO + {4'h0, sh[3:0]};
        else           return TERM;
    endfunction

    assign press_ev_s  = numPressed & ~np_hist_r;
    assign clear_ev_s  = clear      & ~clear_hist_r;
    assign submit_ev_s = submit     & ~submit_hist_r;

    assign digits = digits_r;
    assign count  = count_r;
    assign busy   = busy_r;

    // Buffer update, event priority and byte sequencing.
    always_comb begin
        digits_s    = digits_r;
        count_s     = count_r;
        busy_s      = busy_r;
        idx_s       = idx_r;
        sh_digits_s = sh_digits_r;
        sh_count_s  = sh_count_r;
        start_s     = 1'b0;
        tx_byte_s   = TERM;
        if (busy_r) begin
            // All keypad events are ignored while a transmission runs.
            if (done_s) begin
                if (idx_r != sh_count_r) begin
                    start_s   = 1'b1;
                    idx_s     = idx_r + CW'(1);
                    tx_byte_s = pick_byte(sh_digits_r, sh_count_r, idx_s);
                end else begin
                    busy_s   = 1'b0;
                    idx_s    = '0;
                    digits_s = '0;
                    count_s  = '0;
                end
            end else begin
                busy_s = 1'b1;
            end
        end else if (submit_ev_s) begin
            if (count_r != '0) begin
                start_s     = 1'b1;
                busy_s      = 1'b1;
                idx_s       = '0;
                sh_digits_s = digits_r;
                sh_count_s  = count_r;
                tx_byte_s   = pick_byte(digits_r, count_r, '0);
            end else begin
                busy_s = 1'b0;
            end
        end else if (clear_ev_s) begin
            digits_s = '0;
            count_s  = '0;
        end else if (press_ev_s && (num <= 4'd9)) begin
            digits_s = (digits_r << 4) | DW'(num);
            if (count_r != FULL_C) count_s = count_r + CW'(1);
            else                   count_s = count_r;
        end else begin
            busy_s = 1'b0;
        end
    end

    // Edge history, buffer, shadow and sequencer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            np_hist_r     <= 1'b0;
            clear_hist_r  <= 1'b0;
            submit_hist_r <= 1'b0;
            digits_r      <= '0;
            count_r       <= '0;
            sh_digits_r   <= '0;
            sh_count_r    <= '0;
            idx_r         <= '0;
            busy_r        <= 1'b0;
        end else begin
            np_hist_r     <= numPressed;
            clear_hist_r  <= clear;
            submit_hist_r <= submit;
            digits_r      <= digits_s;
            count_r       <= count_s;
            sh_digits_r   <= sh_digits_s;
            sh_count_r    <= sh_count_s;
            idx_r         <= idx_s;
            busy_r        <= busy_s;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk   (clk),
        .reset (reset),
        .start (start_s),
        .data  (tx_byte_s),
        .done  (done_s),
        .txd   (txd)
    );

    keypad_uart_tx_chk #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CW           (CW)
    ) u_chk (
        .clk   (clk),
        .reset (reset),
        .busy  (busy_r),
        .txd   (txd),
        .count (count_r)
    );

endmodule

// File: tb/tb_keypad_uart_tx.sv
// Testbench for keypad_uart_tx with DIGITS = 4, CLKS_PER_BIT = 4.
module tb_keypad_uart_tx;
    import keypad_tx_pkg::*;

    localparam int DIGITS = 4;
    localparam int CPB    = 4;
`ifdef TX_PARITY_EN
    localparam int FB      = 11;
    localparam int LEN_ONE = 88;
`else
    localparam int FB      = 10;
    localparam int LEN_ONE = 80;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  num = 4'd0;
    logic        numPressed = 1'b0;
    logic        clear = 1'b0;
    logic        submit = 1'b0;
    logic [15:0] digits;
    logic [2:0]  count;
    logic        busy;
    logic        txd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    keypad_uart_tx #(
        .DIGITS       (DIGITS),
        .CLKS_PER_BIT (CPB),
        .TERM         (8'h0D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .num        (num),
        .numPressed (numPressed),
        .clear      (clear),
        .submit     (submit),
        .digits     (digits),
        .count      (count),
        .busy       (busy),
        .txd        (txd)
    );

    typedef struct {
        logic [3:0]  num;
        logic        np;
        logic        clr;
        logic        sub;
        logic [15:0] exp_digits;
        logic [2:0]  exp_count;
    } vec_t;

    vec_t       vecs[20];
    logic [7:0] exp_bytes[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected UART line level for bit k of the frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0)      return 1'b0;
        else if (k <= 8) return b[3'(k - 1)];
`ifdef TX_PARITY_EN
        else if (k == 9) return ^b;
`endif
        else             return 1'b1;
    endfunction

    task automatic press(input logic [3:0] d);
        num = d;
        numPressed = 1'b1;
        @(negedge clk);
        numPressed = 1'b0;
        @(negedge clk);
    endtask

    // Pulse submit, then check busy/txd every cycle of the transmission.
    task automatic run_tx(input int nbytes, input int exp_len, input bit poke);
        int byte_no;
        int bit_no;
        logic [7:0] cur;
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        for (int i = 0; i < exp_len; i++) begin
            byte_no = i / (FB * CPB);
            bit_no  = (i / CPB) % FB;
            cur     = (byte_no < nbytes) ? exp_bytes[3'(byte_no)] : 8'hFF;
            check("busy_tx", 32'(busy), 32'd1);
            check("txd_bit", 32'(txd), 32'(frame_bit(cur, bit_no)));
            if (poke) begin
                case (i)
                    20: begin num = 4'd5; numPressed = 1'b1; end
                    22: numPressed = 1'b0;
                    30: begin
                        check("press_busy_digits", 32'(digits), 32'h0008);
                        check("press_busy_count", 32'(count), 32'd1);
                    end
                    40: clear = 1'b1;
                    42: clear = 1'b0;
                    50: check("clear_busy_digits", 32'(digits), 32'h0008);
                    default: ;
                endcase
            end
            @(negedge clk);
        end
        check("busy_end", 32'(busy), 32'd0);
        check("txd_end", 32'(txd), 32'd1);
        check("count_end", 32'(count), 32'd0);
        check("digits_end", 32'(digits), 32'h0000);
    endtask

    initial begin
        // inputs: num np clr sub -> expected digits, count
        vecs[0]  = '{4'd8,  1'b1, 1'b0, 1'b0, 16'h0008, 3'd1};
        vecs[1]  = '{4'd8,  1'b1, 1'b0, 1'b0, 16'h0008, 3'd1};
        vecs[2]  = '{4'd8,  1'b0, 1'b0, 1'b0, 16'h0008, 3'd1};
        vecs[3]  = '{4'd0,  1'b0, 1'b1, 1'b0, 16'h0000, 3'd0};
        vecs[4]  = '{4'd1,  1'b1, 1'b0, 1'b0, 16'h0001, 3'd1};
        vecs[5]  = '{4'd1,  1'b0, 1'b0, 1'b0, 16'h0001, 3'd1};
        vecs[6]  = '{4'd2,  1'b1, 1'b0, 1'b0, 16'h0012, 3'd2};
        vecs[7]  = '{4'd2,  1'b0, 1'b0, 1'b0, 16'h0012, 3'd2};
        vecs[8]  = '{4'd3,  1'b1, 1'b0, 1'b0, 16'h0123, 3'd3};
        vecs[9]  = '{4'd3,  1'b0, 1'b0, 1'b0, 16'h0123, 3'd3};
        vecs[10] = '{4'd4,  1'b1, 1'b0, 1'b0, 16'h1234, 3'd4};
        vecs[11] = '{4'd4,  1'b0, 1'b0, 1'b0, 16'h1234, 3'd4};
        vecs[12] = '{4'd5,  1'b1, 1'b0, 1'b0, 16'h2345, 3'd4};
        vecs[13] = '{4'd5,  1'b0, 1'b0, 1'b0, 16'h2345, 3'd4};
        vecs[14] = '{4'd10, 1'b1, 1'b0, 1'b0, 16'h2345, 3'd4};
        vecs[15] = '{4'd10, 1'b0, 1'b0, 1'b0, 16'h2345, 3'd4};
        vecs[16] = '{4'd7,  1'b1, 1'b1, 1'b0, 16'h0000, 3'd0};
        vecs[17] = '{4'd0,  1'b0, 1'b0, 1'b0, 16'h0000, 3'd0};
        vecs[18] = '{4'd0,  1'b0, 1'b0, 1'b1, 16'h0000, 3'd0};
        vecs[19] = '{4'd0,  1'b0, 1'b0, 1'b0, 16'h0000, 3'd0};

        // Reset held for two cycles.
        @(negedge clk);
        @(negedge clk);
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_digits", 32'(digits), 32'h0000);
        reset = 1'b0;
        @(negedge clk);

        // Table: single press, clear, buffer limits, same-cycle priority, empty submit.
        for (int v = 0; v < 20; v++) begin
            num        = vecs[v].num;
            numPressed = vecs[v].np;
            clear      = vecs[v].clr;
            submit     = vecs[v].sub;
            @(negedge clk);
            check($sformatf("vec%0d_digits", v), 32'(digits), 32'(vecs[v].exp_digits));
            check($sformatf("vec%0d_count", v), 32'(count), 32'(vecs[v].exp_count));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
            check($sformatf("vec%0d_txd", v), 32'(txd), 32'd1);
        end
        numPressed = 1'b0;
        submit     = 1'b0;
        @(negedge clk);

        // Press "8" held two cycles, then submit; presses/clears during busy ignored.
        num = 4'd8;
        numPressed = 1'b1;
        @(negedge clk);
        @(negedge clk);
        numPressed = 1'b0;
        @(negedge clk);
        check("single_count", 32'(count), 32'd1);
        check("single_digits", 32'(digits), 32'h0008);
        exp_bytes[0] = 8'h38;
        exp_bytes[1] = 8'h0D;
        run_tx(2, LEN_ONE, 1'b1);

        // Four digits go out oldest first, then the terminator.
        press(4'd2);
        press(4'd3);
        press(4'd4);
        press(4'd5);
        check("four_digits", 32'(digits), 32'h2345);
        check("four_count", 32'(count), 32'd4);
        exp_bytes[0] = 8'h32;
        exp_bytes[1] = 8'h33;
        exp_bytes[2] = 8'h34;
        exp_bytes[3] = 8'h35;
        exp_bytes[4] = 8'h0D;
        run_tx(5, int'(busy_cycles(32'd4, 32'(CPB))), 1'b0);

        // Reset during a data bit of '4' (0x34, bit 1 = 0).
        press(4'd4);
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        check("pre_reset_txd", 32'(txd), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_txd", 32'(txd), 32'd1);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_count", 32'(count), 32'd0);
        check("midreset_digits", 32'(digits), 32'h0000);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_reset_txd", 32'(txd), 32'd1);
            check("post_reset_busy", 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t reached, expected completion earlier", $time);
        $fatal(1);
    end

endmodule
